// File: rtl/cmat_mul_seq_if.sv
// Bundle of all non-clock/reset signals of cmat_mul_seq.
//   start/flush_i      : job control from the host
//   a_row_* / b_row_*  : row read requests to A and B^T memories and their tagged responses
//   dot_*              : request/response handshakes with the external complex dot-product unit
//   c_row_*            : result row output handshake
//   in_ready_o/busy_o  : status
// Modport slave is the cmat_mul_seq view; master is the surrounding environment.
interface cmat_mul_seq_if #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(SIZE)
) ();
  localparam int unsigned RowW = SIZE * 2 * WIDTH;
  localparam int unsigned OpW  = 4 * SIZE * WIDTH;

  logic              start;
  logic              flush_i;
  logic [AW-1:0]     a_row_addr_o;
  logic              a_row_addr_valid_o;
  logic [RowW-1:0]   a_row_i;
  logic              a_row_valid_i;
  logic [AW-1:0]     a_row_addr_i;
  logic [AW-1:0]     b_row_addr_o;
  logic              b_row_addr_valid_o;
  logic [RowW-1:0]   b_row_i;
  logic              b_row_valid_i;
  logic [AW-1:0]     b_row_addr_i;
  logic [OpW-1:0]    dot_operands_o;
  logic              dot_in_valid_o;
  logic              dot_in_ready_i;
  logic [2*WIDTH-1:0] dot_result_i;
  logic              dot_out_valid_i;
  logic              dot_out_ready_o;
  logic [RowW-1:0]   c_row_o;
  logic [AW-1:0]     c_row_addr_o;
  logic              c_row_valid_o;
  logic              c_row_out_ready_i;
  logic              in_ready_o;
  logic              busy_o;

  modport slave (
    input  start, flush_i,
    output a_row_addr_o, a_row_addr_valid_o,
    input  a_row_i, a_row_valid_i, a_row_addr_i,
    output b_row_addr_o, b_row_addr_valid_o,
    input  b_row_i, b_row_valid_i, b_row_addr_i,
    output dot_operands_o, dot_in_valid_o,
    input  dot_in_ready_i, dot_result_i, dot_out_valid_i,
    output dot_out_ready_o,
    output c_row_o, c_row_addr_o, c_row_valid_o,
    input  c_row_out_ready_i,
    output in_ready_o, busy_o
  );

  modport master (
    output start, flush_i,
    input  a_row_addr_o, a_row_addr_valid_o,
    output a_row_i, a_row_valid_i, a_row_addr_i,
    input  b_row_addr_o, b_row_addr_valid_o,
    output b_row_i, b_row_valid_i, b_row_addr_i,
    input  dot_operands_o, dot_in_valid_o,
    output dot_in_ready_i, dot_result_i, dot_out_valid_i,
    input  dot_out_ready_o,
    input  c_row_o, c_row_addr_o, c_row_valid_o,
    output c_row_out_ready_i,
    input  in_ready_o, busy_o
  );
endinterface

// File: rtl/cmat_mul_seq.sv
// Sequential complex matrix multiply controller: C = A * B, one output element at a time.
// Fetches row i of A once per output row, then for each j fetches row j of B^T, hands both
// rows to an external dot-product unit, and stores the result in slot j of the C row buffer.
// The finished row is emitted on the c_row handshake.
// Ports: clk_i, rst_ni (synchronous, active low) and bus (cmat_mul_seq_if.slave).
module cmat_mul_seq #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(SIZE)
) (
  input logic           clk_i,
  input logic           rst_ni,
  cmat_mul_seq_if.slave bus
);
  localparam int unsigned ElemW = 2 * WIDTH;
  localparam int unsigned RowW  = SIZE * ElemW;
  localparam int unsigned OpW   = 4 * SIZE * WIDTH;
  localparam logic [AW-1:0] Last = AW'(SIZE - 1);

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StIssue, StCollect, StWrite} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   i_q, i_d, j_q, j_d;
  logic            req_sent_q, req_sent_d;
  logic            dot_pend_q, dot_pend_d;
  logic [RowW-1:0] a_buf_q, a_buf_d, b_buf_q, b_buf_d, c_buf_q, c_buf_d;

  logic            a_req, b_req, dot_in_valid, c_valid;
  logic [OpW-1:0]  ops;

  // Interleave the latched rows into {A re, A im, B re, B im} words per k.
  always_comb begin
    ops = '0;
    for (int k = 0; k < SIZE; k++) begin
      ops[(4*k+0)*WIDTH +: WIDTH] = a_buf_q[k*ElemW +: WIDTH];
      ops[(4*k+1)*WIDTH +: WIDTH] = a_buf_q[k*ElemW + WIDTH +: WIDTH];
      ops[(4*k+2)*WIDTH +: WIDTH] = b_buf_q[k*ElemW +: WIDTH];
      ops[(4*k+3)*WIDTH +: WIDTH] = b_buf_q[k*ElemW + WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    req_sent_d   = req_sent_q;
    dot_pend_d   = dot_pend_q;
    a_buf_d      = a_buf_q;
    b_buf_d      = b_buf_q;
    c_buf_d      = c_buf_q;
    a_req        = 1'b0;
    b_req        = 1'b0;
    dot_in_valid = 1'b0;
    c_valid      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          i_d        = '0;
          j_d        = '0;
          req_sent_d = 1'b0;
          state_d    = StRdA;
        end
      end
      StRdA: begin
        // Single-cycle request strobe; responses are only taken after it went out.
        a_req      = !req_sent_q;
        req_sent_d = 1'b1;
        if (req_sent_q && bus.a_row_valid_i && (bus.a_row_addr_i == i_q)) begin
          a_buf_d    = bus.a_row_i;
          req_sent_d = 1'b0;
          state_d    = StRdB;
        end
      end
      StRdB: begin
        b_req      = !req_sent_q;
        req_sent_d = 1'b1;
        if (req_sent_q && bus.b_row_valid_i && (bus.b_row_addr_i == j_q)) begin
          b_buf_d    = bus.b_row_i;
          req_sent_d = 1'b0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        // A result from an aborted job may still be draining; keep one op outstanding.
        dot_in_valid = !dot_pend_q;
        if (dot_in_valid && bus.dot_in_ready_i) state_d = StCollect;
      end
      StCollect: begin
        if (bus.dot_out_valid_i && dot_pend_q) begin
          c_buf_d[int'(j_q)*ElemW +: ElemW] = bus.dot_result_i;
          if (j_q != Last) begin
            j_d     = j_q + 1'b1;
            state_d = StRdB;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        c_valid = 1'b1;
        if (bus.c_row_out_ready_i) begin
          if (i_q != Last) begin
            i_d     = i_q + 1'b1;
            j_d     = '0;
            state_d = StRdA;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outstanding-op tracking survives flush so a late result is drained, not reused.
    if (dot_in_valid && bus.dot_in_ready_i) dot_pend_d = 1'b1;
    if (dot_pend_q && bus.dot_out_valid_i)  dot_pend_d = 1'b0;

    if (bus.flush_i) begin
      state_d    = StIdle;
      req_sent_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      i_q        <= '0;
      j_q        <= '0;
      req_sent_q <= 1'b0;
      dot_pend_q <= 1'b0;
      a_buf_q    <= '0;
      b_buf_q    <= '0;
      c_buf_q    <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      req_sent_q <= req_sent_d;
      dot_pend_q <= dot_pend_d;
      a_buf_q    <= a_buf_d;
      b_buf_q    <= b_buf_d;
      c_buf_q    <= c_buf_d;
    end
  end

  assign bus.a_row_addr_o       = i_q;
  assign bus.a_row_addr_valid_o = a_req;
  assign bus.b_row_addr_o       = j_q;
  assign bus.b_row_addr_valid_o = b_req;
  assign bus.dot_operands_o     = ops;
  assign bus.dot_in_valid_o     = dot_in_valid;
  assign bus.dot_out_ready_o    = dot_pend_q;
  assign bus.c_row_o            = c_buf_q;
  assign bus.c_row_addr_o       = i_q;
  assign bus.c_row_valid_o      = c_valid;
  assign bus.in_ready_o         = (state_q == StIdle);
  assign bus.busy_o             = (state_q != StIdle);
endmodule

// File: tb/tb_cmat_mul_seq.sv
module tb_cmat_mul_seq;
  localparam int unsigned SIZE  = 2;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned AW    = 1;
  localparam int unsigned EW    = 2 * WIDTH;
  localparam int unsigned RW    = SIZE * EW;
  localparam int unsigned OW    = 4 * SIZE * WIDTH;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [RW-1:0] row;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  cmat_mul_seq_if #(.SIZE(SIZE), .WIDTH(WIDTH), .AW(AW)) bus ();
  cmat_mul_seq #(.SIZE(SIZE), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  real ma_re[SIZE][SIZE], ma_im[SIZE][SIZE], mb_re[SIZE][SIZE], mb_im[SIZE][SIZE];
  logic [RW-1:0] a_mem[SIZE];
  logic [RW-1:0] b_mem[SIZE];

  int ready_delay  = 0;
  int result_delay = 0;
  bit stale_en     = 1'b0;
  int a_req_cnt    = 0;
  int b_req_cnt    = 0;
  int unstable_cnt = 0;

  // Reference complex dot product on packed operand words.
  function automatic logic [EW-1:0] dot_ref(input logic [OW-1:0] ops);
    real sr, si, ar, ai, br, bi;
    sr = 0.0; si = 0.0;
    for (int k = 0; k < SIZE; k++) begin
      ar = $bitstoreal(ops[(4*k+0)*WIDTH +: WIDTH]);
      ai = $bitstoreal(ops[(4*k+1)*WIDTH +: WIDTH]);
      br = $bitstoreal(ops[(4*k+2)*WIDTH +: WIDTH]);
      bi = $bitstoreal(ops[(4*k+3)*WIDTH +: WIDTH]);
      sr = sr + ar * br - ai * bi;
      si = si + ar * bi + ai * br;
    end
    return {$realtobits(si), $realtobits(sr)};
  endfunction

  // Expected row i of C computed directly from the matrices.
  function automatic logic [RW-1:0] exp_row(input int i);
    logic [RW-1:0] r;
    real sr, si;
    r = '0;
    for (int j = 0; j < SIZE; j++) begin
      sr = 0.0; si = 0.0;
      for (int k = 0; k < SIZE; k++) begin
        sr = sr + ma_re[i][k] * mb_re[j][k] - ma_im[i][k] * mb_im[j][k];
        si = si + ma_re[i][k] * mb_im[j][k] + ma_im[i][k] * mb_re[j][k];
      end
      r[j*EW +: EW] = {$realtobits(si), $realtobits(sr)};
    end
    return r;
  endfunction

  task automatic load_mats(input bit general);
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ma_re[i][k] = (i == k) ? 1.0 : 0.0;
        ma_im[i][k] = 0.0;
      end
    if (general) begin
      ma_re[0][0] = 2.0;  ma_im[0][1] = 1.0;
      ma_re[1][0] = -1.0; ma_re[1][1] = 3.0; ma_im[1][1] = 1.0;
    end
    mb_re[0][0] = 1.0; mb_im[0][0] = 2.0; mb_re[0][1] = 3.0; mb_im[0][1] = 0.0;
    mb_re[1][0] = 0.0; mb_im[1][0] = 4.0; mb_re[1][1] = 5.0; mb_im[1][1] = 0.0;
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        a_mem[i][k*EW +: EW] = {$realtobits(ma_im[i][k]), $realtobits(ma_re[i][k])};
        b_mem[i][k*EW +: EW] = {$realtobits(mb_im[i][k]), $realtobits(mb_re[i][k])};
      end
  endtask

  task automatic push_row(input int i);
    exp_t e;
    e.addr = AW'(i);
    e.row  = exp_row(i);
    exp_q.push_back(e);
  endtask

  task automatic start_job();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for a row handshake; no judgement made here.
  task automatic wait_row(input int budget, output bit got, output logic [AW-1:0] addr,
                          output logic [RW-1:0] row, output int cyc);
    got = 1'b0; cyc = 0; addr = '0; row = '0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.c_row_valid_o && bus.c_row_out_ready_i) begin
        got = 1'b1; addr = bus.c_row_addr_o; row = bus.c_row_o;
      end
    end
  endtask

  // Memory models: one-cycle latency, tagged responses.
  initial begin : a_mem_model
    logic req; logic [AW-1:0] addr;
    bus.a_row_valid_i = 1'b0; bus.a_row_addr_i = '0; bus.a_row_i = '0;
    forever begin
      @(negedge clk);
      req = bus.a_row_addr_valid_o; addr = bus.a_row_addr_o;
      if (req) a_req_cnt++;
      @(posedge clk); #1;
      if (req && rst_ni) begin
        if (stale_en && addr == '0) begin
          bus.a_row_valid_i = 1'b1; bus.a_row_addr_i = AW'(1); bus.a_row_i = a_mem[1];
          @(posedge clk); #1;
        end
        bus.a_row_valid_i = 1'b1; bus.a_row_addr_i = addr; bus.a_row_i = a_mem[addr];
      end else begin
        bus.a_row_valid_i = 1'b0;
      end
    end
  end

  initial begin : b_mem_model
    logic req; logic [AW-1:0] addr;
    bus.b_row_valid_i = 1'b0; bus.b_row_addr_i = '0; bus.b_row_i = '0;
    forever begin
      @(negedge clk);
      req = bus.b_row_addr_valid_o; addr = bus.b_row_addr_o;
      if (req) b_req_cnt++;
      @(posedge clk); #1;
      if (req && rst_ni) begin
        bus.b_row_valid_i = 1'b1; bus.b_row_addr_i = addr; bus.b_row_i = b_mem[addr];
      end else begin
        bus.b_row_valid_i = 1'b0;
      end
    end
  end

  // Dot unit model with configurable ready and result delays.
  initial begin : dot_model
    logic in_v, in_hs, out_hs, prev_wait, have_res;
    logic [OW-1:0] ops, prev_ops;
    logic [EW-1:0] res;
    int wait_cnt, res_cnt;
    bus.dot_in_ready_i = 1'b0; bus.dot_out_valid_i = 1'b0; bus.dot_result_i = '0;
    prev_wait = 1'b0; prev_ops = '0; have_res = 1'b0; res = '0; wait_cnt = 0; res_cnt = 0;
    forever begin
      @(negedge clk);
      in_v   = bus.dot_in_valid_o;
      in_hs  = in_v && bus.dot_in_ready_i;
      out_hs = bus.dot_out_valid_i && bus.dot_out_ready_o;
      ops    = bus.dot_operands_o;
      if (prev_wait && in_v && ops !== prev_ops) unstable_cnt++;
      prev_wait = in_v && !in_hs;
      prev_ops  = ops;
      @(posedge clk); #1;
      if (!rst_ni) begin
        have_res = 1'b0; wait_cnt = 0; prev_wait = 1'b0;
        bus.dot_out_valid_i = 1'b0;
        bus.dot_in_ready_i  = (ready_delay == 0);
      end else begin
        if (out_hs) begin bus.dot_out_valid_i = 1'b0; have_res = 1'b0; end
        if (in_hs) begin
          res = dot_ref(ops); have_res = 1'b1; res_cnt = result_delay; wait_cnt = 0;
        end else if (in_v) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
        end
        bus.dot_in_ready_i = (ready_delay == 0) || (!in_hs && in_v && wait_cnt >= ready_delay);
        if (have_res && !bus.dot_out_valid_i) begin
          if (res_cnt == 0) begin
            bus.dot_out_valid_i = 1'b1; bus.dot_result_i = res;
          end else begin
            res_cnt--;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_ready_o, bus.busy_o, bus.a_row_addr_valid_o, bus.b_row_addr_valid_o,
         bus.dot_in_valid_o, bus.dot_out_ready_o, bus.c_row_valid_o} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1000000", {bus.in_ready_o, bus.busy_o,
               bus.a_row_addr_valid_o, bus.b_row_addr_valid_o, bus.dot_in_valid_o,
               bus.dot_out_ready_o, bus.c_row_valid_o});
    end
    checks++;
    if (bus.c_row_o !== '0 || bus.dot_operands_o !== '0 || bus.c_row_addr_o !== '0) begin
      failures++;
      $display("FAIL reset_data c_row=%h c_addr=%0d ops_nonzero=%0b exp zeros",
               bus.c_row_o, bus.c_row_addr_o, bus.dot_operands_o !== '0);
    end
    rst_ni = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release in_ready=%b busy=%b exp 1/0", bus.in_ready_o, bus.busy_o);
    end
  endtask

  task automatic test_identity();
    bit got; logic [AW-1:0] addr; logic [RW-1:0] row; int cyc; exp_t e;
    int a0, b0;
    load_mats(1'b0);
    ready_delay = 0; result_delay = 0;
    a0 = a_req_cnt; b0 = b_req_cnt;
    push_row(0); push_row(1);
    start_job();
    for (int r = 0; r < SIZE; r++) begin
      wait_row(60, got, addr, row, cyc);
      e = exp_q.pop_front();
      checks++;
      if (!got || addr !== e.addr || row !== e.row) begin
        failures++;
        $display("FAIL ident_row%0d got=%0b addr=%0d row=%h exp addr=%0d row=%h",
                 r, got, addr, row, e.addr, e.row);
      end
      checks++;
      if (cyc !== (r == 0 ? 10 : 11)) begin
        failures++;
        $display("FAIL ident_latency%0d cycles=%0d exp=%0d", r, cyc, (r == 0 ? 10 : 11));
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL ident_busy_fall busy=%b in_ready=%b exp 0/1", bus.busy_o, bus.in_ready_o);
    end
    checks++;
    if (a_req_cnt - a0 !== 2 || b_req_cnt - b0 !== 4) begin
      failures++;
      $display("FAIL ident_fetch_count a=%0d b=%0d exp a=2 b=4", a_req_cnt - a0, b_req_cnt - b0);
    end
  endtask

  task automatic test_dot_stall();
    bit got; logic [AW-1:0] addr; logic [RW-1:0] row; int cyc; exp_t e; int u0;
    load_mats(1'b0);
    ready_delay = 5; result_delay = 3;
    u0 = unstable_cnt;
    push_row(0); push_row(1);
    start_job();
    for (int r = 0; r < SIZE; r++) begin
      wait_row(200, got, addr, row, cyc);
      e = exp_q.pop_front();
      checks++;
      if (!got || addr !== e.addr || row !== e.row) begin
        failures++;
        $display("FAIL stall_row%0d got=%0b addr=%0d row=%h exp addr=%0d row=%h",
                 r, got, addr, row, e.addr, e.row);
      end
    end
    checks++;
    if (unstable_cnt - u0 !== 0) begin
      failures++;
      $display("FAIL stall_operand_stable changes=%0d exp=0", unstable_cnt - u0);
    end
    ready_delay = 0; result_delay = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit got; logic [AW-1:0] addr; logic [RW-1:0] row; int cyc; exp_t e;
    int viol, b0; bit seen;
    load_mats(1'b1);
    bus.c_row_out_ready_i = 1'b0;
    push_row(0); push_row(1);
    start_job();
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk); cyc++;
      seen = bus.c_row_valid_o;
    end
    addr = bus.c_row_addr_o; row = bus.c_row_o;
    b0 = b_req_cnt; viol = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.c_row_valid_o !== 1'b1 || bus.c_row_addr_o !== addr || bus.c_row_o !== row ||
          bus.b_row_addr_valid_o !== 1'b0) viol++;
    end
    bus.c_row_out_ready_i = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (!seen || addr !== e.addr || row !== e.row) begin
      failures++;
      $display("FAIL bp_row0 got=%0b addr=%0d row=%h exp addr=%0d row=%h",
               seen, addr, row, e.addr, e.row);
    end
    checks++;
    if (viol !== 0 || b_req_cnt - b0 !== 0) begin
      failures++;
      $display("FAIL bp_hold violations=%0d b_reads=%0d exp 0/0", viol, b_req_cnt - b0);
    end
    wait_row(60, got, addr, row, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!got || addr !== e.addr || row !== e.row) begin
      failures++;
      $display("FAIL bp_row1 got=%0b addr=%0d row=%h exp addr=%0d row=%h",
               got, addr, row, e.addr, e.row);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_flush();
    bit got; logic [AW-1:0] addr; logic [RW-1:0] row; int cyc; exp_t e; int stray; bit hs;
    load_mats(1'b1);
    ready_delay = 0; result_delay = 3;
    push_row(0);
    start_job();
    wait_row(100, got, addr, row, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!got || addr !== e.addr || row !== e.row) begin
      failures++;
      $display("FAIL flush_row0 got=%0b addr=%0d row=%h exp addr=%0d row=%h",
               got, addr, row, e.addr, e.row);
    end
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 40) begin
      @(negedge clk); cyc++;
      hs = bus.dot_in_valid_o && bus.dot_in_ready_i;
    end
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    checks++;
    if (!hs || {bus.busy_o, bus.a_row_addr_valid_o, bus.b_row_addr_valid_o,
                bus.dot_in_valid_o, bus.c_row_valid_o} !== 5'b0) begin
      failures++;
      $display("FAIL flush_idle hs=%0b busy/av/bv/dv/cv=%b exp 00000", hs, {bus.busy_o,
               bus.a_row_addr_valid_o, bus.b_row_addr_valid_o, bus.dot_in_valid_o,
               bus.c_row_valid_o});
    end
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.c_row_valid_o) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL flush_no_row1 stray_valid_cycles=%0d exp=0", stray);
    end
    load_mats(1'b0);
    result_delay = 0;
    push_row(0); push_row(1);
    start_job();
    for (int r = 0; r < SIZE; r++) begin
      wait_row(100, got, addr, row, cyc);
      e = exp_q.pop_front();
      checks++;
      if (!got || addr !== e.addr || row !== e.row) begin
        failures++;
        $display("FAIL flush_rerun_row%0d got=%0b addr=%0d row=%h exp addr=%0d row=%h",
                 r, got, addr, row, e.addr, e.row);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stale_tag();
    bit got; logic [AW-1:0] addr; logic [RW-1:0] row; int cyc; exp_t e;
    load_mats(1'b1);
    stale_en = 1'b1;
    push_row(0); push_row(1);
    start_job();
    for (int r = 0; r < SIZE; r++) begin
      wait_row(100, got, addr, row, cyc);
      e = exp_q.pop_front();
      checks++;
      if (!got || addr !== e.addr || row !== e.row) begin
        failures++;
        $display("FAIL stale_row%0d got=%0b addr=%0d row=%h exp addr=%0d row=%h",
                 r, got, addr, row, e.addr, e.row);
      end
    end
    stale_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_reset();
    int a0, cyc, stray; bit issue;
    load_mats(1'b1);
    ready_delay = 5; result_delay = 0;
    a0 = a_req_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    issue = 1'b0; cyc = 0;
    while (!issue && cyc < 40) begin
      @(negedge clk); cyc++;
      issue = bus.dot_in_valid_o;
    end
    checks++;
    if (!issue || a_req_cnt - a0 !== 1) begin
      failures++;
      $display("FAIL start_held_single_job issue=%0b a_reads=%0d exp 1/1", issue, a_req_cnt - a0);
    end
    @(negedge clk);
    rst_ni = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    checks++;
    if ({bus.in_ready_o, bus.busy_o, bus.a_row_addr_valid_o, bus.b_row_addr_valid_o,
         bus.dot_in_valid_o, bus.dot_out_ready_o, bus.c_row_valid_o} !== 7'b1000000 ||
        bus.c_row_o !== '0 || bus.dot_operands_o !== '0) begin
      failures++;
      $display("FAIL midjob_reset ctrl=%b data_nonzero=%0b exp 1000000/0", {bus.in_ready_o,
               bus.busy_o, bus.a_row_addr_valid_o, bus.b_row_addr_valid_o, bus.dot_in_valid_o,
               bus.dot_out_ready_o, bus.c_row_valid_o},
               (bus.c_row_o !== '0) || (bus.dot_operands_o !== '0));
    end
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.c_row_valid_o || bus.busy_o) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL reset_no_relaunch active_cycles=%0d exp=0", stray);
    end
    ready_delay = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bus.start = 1'b0;
    bus.flush_i = 1'b0;
    bus.c_row_out_ready_i = 1'b1;
    load_mats(1'b0);
    test_reset();
    test_identity();
    test_dot_stall();
    test_backpressure();
    test_flush();
    test_stale_tag();
    test_start_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmat_mul_seq.md
CMAT_MUL_SEQ -- requirements
Module: cmat_mul_seq

Interface
REQ-001 Parameter SIZE, default 16, matrix dimension (SIZE x SIZE complex).
REQ-002 Parameter WIDTH, default 64, bits per real/imag part (IEEE-754 double).
REQ-003 Parameter AW, default $clog2(SIZE), row-address width.
REQ-004 Clocking: one clock; reset synchronous, active-low; all ports below.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_ni  in  1  synchronous active-low reset.
REQ-007 start  in  1  begin C = A*B; sampled in IDLE only.
REQ-008 flush_i  in  1  abort job, return to IDLE.
REQ-009 a_row_addr_o  out  AW  row of A requested.
REQ-010 a_row_addr_valid_o  out  1  A read-request strobe.
REQ-011 a_row_i  in  SIZE*2*WIDTH  A row; element k = {imag, real} at [k*2*WIDTH +: 2*WIDTH].
REQ-012 a_row_valid_i  in  1  A row data valid.
REQ-013 a_row_addr_i  in  AW  address tag of returned A row.
REQ-014 b_row_addr_o, b_row_addr_valid_o, b_row_i, b_row_valid_i, b_row_addr_i: same widths and meanings as the A port; B is stored transposed (B row j = column j of B).
REQ-015 dot_operands_o  out  4*SIZE*WIDTH  word 4k = A re, 4k+1 = A im, 4k+2 = B re, 4k+3 = B im.
REQ-016 dot_in_valid_o / dot_in_ready_i  out/in  1  dot-product unit request handshake.
REQ-017 dot_result_i  in  2*WIDTH  {imag, real} of sum over k of A[i][k]*B[k][j].
REQ-018 dot_out_valid_i / dot_out_ready_o  in/out  1  dot-product result handshake.
REQ-019 c_row_o  out  SIZE*2*WIDTH  result row, same packing as a_row_i.
REQ-020 c_row_addr_o  out  AW  result row index i.
REQ-021 c_row_valid_o / c_row_out_ready_i  out/in  1  result row handshake.
REQ-022 in_ready_o  out  1  high only in IDLE.
REQ-023 busy_o  out  1  high in every state except IDLE.

Function
REQ-024 FSM states: IDLE, RD_A, RD_B, ISSUE, COLLECT, WRITE.
REQ-025 IDLE: on start=1, i=0, j=0, go to RD_A; start outside IDLE is ignored.
REQ-026 RD_A: a_row_addr_valid_o=1 for exactly one cycle with addr i; wait for a_row_valid_i with a_row_addr_i==i; latch row; go to RD_B; rows with mismatched tags are dropped.
REQ-027 RD_B: identical protocol on the B port with addr j; latch row; go to ISSUE.
REQ-028 ISSUE: dot_in_valid_o=1 with operands packed from latched rows; hold operands and valid stable until dot_in_ready_i=1; then go to COLLECT.
REQ-029 COLLECT: dot_out_ready_o=1; on dot_out_valid_i store dot_result_i in row buffer slot j; if j<SIZE-1, j++ and go to RD_B; otherwise go to WRITE.
REQ-030 At most one dot operation is outstanding at a time.
REQ-031 The A row is fetched once per output row i and is not refetched for each j.
REQ-032 WRITE: c_row_valid_o=1, c_row_addr_o=i; hold data and valid until c_row_out_ready_i=1. Then, if i<SIZE-1, i++, j=0, go to RD_A; otherwise go to IDLE.
REQ-033 Minimum latency per element: RD_B 2 + ISSUE 1 + COLLECT 1 cycles, with 1-cycle memory and zero-wait dot unit.
REQ-034 Counters i and j saturate at SIZE-1 and never wrap.
REQ-035 Data is passed bit-exact; the block performs no arithmetic on operands.
REQ-036 flush_i=1 in any state: next state is IDLE; all valid outputs are 0 next cycle; in-flight memory or dot responses are ignored; flush has priority over start.

Reset
REQ-037 rst_ni=0 at a clock edge: state IDLE, i=j=0.
REQ-038 Reset values: all valid outputs 0; dot_out_ready_o=0; busy_o=0; in_ready_o=1; data outputs 0.
REQ-039 Reset asserted mid-job behaves as flush; no partial row is emitted.

Verification
REQ-040 SIZE=2, A=I, B^T=[[1+2j,3],[4j,5]], with a reference dot model -> C = B (real/imag bit-exact); rows emitted with addr 0 then 1; busy_o falls after the last handshake.
REQ-041 Dot unit adds 5-cycle ready delay and 3-cycle result delay -> dot_operands_o stays stable while waiting; C is unchanged from the zero-wait run.
REQ-042 Hold c_row_out_ready_i=0 for 10 cycles during row 0 -> c_row_valid_o, c_row_o and c_row_addr_o stay constant; no B read is issued until acceptance.
REQ-043 Pulse flush_i during COLLECT of row 1, then start again -> no row-1 output from the aborted job; the new job completes correctly; the stale dot result is ignored.
REQ-044 A memory returns a stale tag (addr 1) before the correct row 0 -> the stale row is ignored; the result matches the reference.
REQ-045 start held high during a job plus rst_ni=0 mid-ISSUE -> no second job is launched; after reset, outputs show the REQ-038 values.
